// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request/grant bundle shared by all writeback sources and the arbiter.
// Sources drive valid/rd/data and keep them stable until they see ready.
interface regfile_wb_arbiter_if #(
  parameter int unsigned NumWbUnits = 4,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned AddrWidth  = 5
);
  logic [NumWbUnits-1:0]                wb_valid;
  logic [NumWbUnits-1:0][AddrWidth-1:0] wb_rd;
  logic [NumWbUnits-1:0][DataWidth-1:0] wb_data;
  logic [NumWbUnits-1:0]                wb_ready;

  modport master (
    output wb_valid,
    output wb_rd,
    output wb_data,
    input  wb_ready
  );

  modport slave (
    input  wb_valid,
    input  wb_rd,
    input  wb_data,
    output wb_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among writeback
// sources. The winner is registered into a one-entry stage; x0 writes are consumed.
module regfile_wb_arbiter #(
  parameter int unsigned NumWbUnits = 4,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned AddrWidth  = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wb_hold_i,
  regfile_wb_arbiter_if.slave  wb,
  output logic [AddrWidth-1:0] rf_rd_addr_o,
  output logic [DataWidth-1:0] rf_new_data_o,
  output logic                 rf_commit_o,
  output logic [15:0]          x0_drop_cnt_o
);

  localparam int unsigned PtrW = (NumWbUnits > 1) ? $clog2(NumWbUnits) : 1;

  logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]       gnt_idx;
  logic [PtrW-1:0]       scan_idx;
  logic [NumWbUnits-1:0] gnt;
  logic                  gnt_any;
  int unsigned           scan;

  logic [AddrWidth-1:0]  sel_rd;
  logic [DataWidth-1:0]  sel_data;

  logic                  commit_q, commit_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [DataWidth-1:0]  data_q, data_d;
  logic [15:0]           cnt_q, cnt_d;

  // Grant depends only on valid, pointer and hold; rd/data never feed ready.
  always_comb begin
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan     = 0;
    scan_idx = '0;
    if (!wb_hold_i) begin
      for (int unsigned off = 0; off < NumWbUnits; off++) begin
        scan = 32'(rr_ptr_q) + off;
        if (scan >= NumWbUnits) begin
          scan = scan - NumWbUnits;
        end
        scan_idx = PtrW'(scan);
        if (!gnt_any && wb.wb_valid[scan_idx]) begin
          gnt[scan_idx] = 1'b1;
          gnt_any       = 1'b1;
          gnt_idx       = scan_idx;
        end
      end
    end
  end

  assign wb.wb_ready = rst_ni ? gnt : '0;

  assign sel_rd   = wb.wb_rd[gnt_idx];
  assign sel_data = wb.wb_data[gnt_idx];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    commit_d = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    if (gnt_any) begin
      rr_ptr_d = (gnt_idx == PtrW'(NumWbUnits - 1)) ? '0 : gnt_idx + 1'b1;
      if (sel_rd != '0) begin
        commit_d = 1'b1;
        addr_d   = sel_rd;
        data_d   = sel_data;
      end else if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      commit_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      commit_q <= commit_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rf_commit_o   = commit_q;
  assign rf_rd_addr_o  = addr_q;
  assign rf_new_data_o = data_q;
  assign x0_drop_cnt_o = cnt_q;

endmodule
